// File: rtl/flag_unit.sv
// flag_unit: captures one word, OR-reduces it a byte per cycle to derive the
// zero flag, then presents the word with zr/ng until downstream accepts it.
// A saturating counter tallies delivered words whose zero flag was set.
//
// Handshake semantics: a word moves upstream->block on an edge where
// in_valid && in_ready, and block->downstream on an edge where
// out_valid && out_ready. out_valid, out_data, zr and ng are held stable
// while out_valid && !out_ready. in_valid is ignored whenever in_ready is 0.
// WIDTH must be a multiple of 8 and at least 8.
module flag_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             zr,
    output logic             ng,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [1:0]       dbg_state
);

    localparam int NBYTES = WIDTH / 8;
    // Keep the index at least one bit wide so an 8-bit build still elaborates.
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   zero_cnt_q, zero_cnt_d;
    logic               byte_or;
    logic               handshake;

    // OR-reduce the hold byte selected by the current scan index.
    always_comb begin
        byte_or = 1'b0;
        for (int b = 0; b < NBYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                byte_or = |hold_q[8*b +: 8];
            end
        end
    end

    // Next-state, datapath and counter updates.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        zero_cnt_d = zero_cnt_q;
        handshake  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    acc_d   = 1'b0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                acc_d = acc_q | byte_or;
                if (idx_q == LAST_IDX) begin
                    idx_d      = '0;
                    out_data_d = hold_q;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear beats a coincident increment; the count sticks at all-ones.
        if (clr_cnt) begin
            zero_cnt_d = '0;
        end else if (handshake && !acc_q && (zero_cnt_q != {CNT_W{1'b1}})) begin
            zero_cnt_d = zero_cnt_q + CNT_W'(1);
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            acc_q      <= 1'b0;
            idx_q      <= '0;
            out_data_q <= '0;
            zero_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign zr        = (state_q == DONE) & ~acc_q;
    assign ng        = (state_q == DONE) & hold_q[WIDTH-1];
    assign out_data  = out_data_q;
    assign zero_cnt  = zero_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed testbench for flag_unit (WIDTH=16, CNT_W=8).
module tb_flag_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        zr;
    logic        ng;
    logic        clr_cnt;
    logic [7:0]  zero_cnt;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;

    flag_unit #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .zr        (zr),
        .ng        (ng),
        .clr_cnt   (clr_cnt),
        .zero_cnt  (zero_cnt),
        .dbg_state (dbg_state)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one word with out_ready high and check every stage of its trip.
    task automatic send_word(input logic [15:0] d, input logic exp_zr,
                             input logic exp_ng, input logic clr);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        step(); // accepting edge
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL accept_%h: in_ready=%b out_valid=%b want 0/0", d, in_ready, out_valid);
            n_err++;
        end
        step(); // byte 0
        n_cmp++;
        if (out_valid !== 1'b0) begin
            $display("FAIL early_valid_%h: out_valid=%b want 0", d, out_valid);
            n_err++;
        end
        step(); // byte 1 -> DONE
        n_cmp++;
        if (out_valid !== 1'b1 || zr !== exp_zr || ng !== exp_ng || out_data !== d) begin
            $display("FAIL done_%h: valid=%b zr=%b ng=%b data=%h want 1/%b/%b/%h",
                     d, out_valid, zr, ng, out_data, exp_zr, exp_ng, d);
            n_err++;
        end
        clr_cnt = clr;
        step(); // handshake
        clr_cnt = 1'b0;
        if (clr) model_cnt = 0;
        else if (exp_zr && model_cnt < 255) model_cnt++;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || zero_cnt !== 8'(model_cnt)) begin
            $display("FAIL handshake_%h: valid=%b in_ready=%b cnt=%0d want 0/1/%0d",
                     d, out_valid, in_ready, zero_cnt, model_cnt);
            n_err++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_cnt = 1'b0;
        step(); step();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || zr !== 1'b0 || ng !== 1'b0 ||
            out_data !== 16'h0000 || zero_cnt !== 8'd0 || dbg_state !== 2'd0) begin
            $display("FAIL reset_state: rdy=%b vld=%b zr=%b ng=%b data=%h cnt=%0d st=%0d want 1/0/0/0/0000/0/0",
                     in_ready, out_valid, zr, ng, out_data, zero_cnt, dbg_state);
            n_err++;
        end
        #2 rst_n = 1'b1;
        step();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
            n_err++;
        end
    endtask

    task automatic test_zero_word();
        send_word(16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_nonzero_words();
        send_word(16'h0100, 1'b0, 1'b0, 1'b0);
        send_word(16'h0001, 1'b0, 1'b0, 1'b0);
        send_word(16'h8000, 1'b0, 1'b1, 1'b0);
        send_word(16'hFFFF, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (zero_cnt !== 8'd1) begin
            $display("FAIL nonzero_cnt: zero_cnt=%0d want 1", zero_cnt);
            n_err++;
        end
    endtask

    // Stall in DONE with a competing word on the input; it must not be taken.
    task automatic test_stall();
        in_valid = 1'b1; in_data = 16'h5A00; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step(); // now in DONE
        in_valid = 1'b1; in_data = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 16'h5A00 || zr !== 1'b0 ||
                ng !== 1'b0 || in_ready !== 1'b0) begin
                $display("FAIL stall_%0d: vld=%b data=%h zr=%b ng=%b rdy=%b want 1/5a00/0/0/0",
                         i, out_valid, out_data, zr, ng, in_ready);
                n_err++;
            end
        end
        out_ready = 1'b1; // handshake edge with in_valid still high
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h5A00 || zero_cnt !== 8'd1) begin
            $display("FAIL stall_release: rdy=%b vld=%b data=%h cnt=%0d want 1/0/5a00/1",
                     in_ready, out_valid, out_data, zero_cnt);
            n_err++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                $display("FAIL stall_no_capture_%0d: vld=%b rdy=%b want 0/1", i, out_valid, in_ready);
                n_err++;
            end
        end
    endtask

    // 300 zero words streamed with in_valid and out_ready held high.
    task automatic test_back_to_back();
        int seen = 0;
        in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b1;
        for (int i = 0; i < 300 * 4; i++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        in_valid = 1'b0;
        model_cnt = (model_cnt + 300 > 255) ? 255 : model_cnt + 300;
        n_cmp++;
        if (seen !== 300) begin
            $display("FAIL b2b_throughput: delivered=%0d want 300", seen);
            n_err++;
        end
        n_cmp++;
        if (zero_cnt !== 8'(model_cnt)) begin
            $display("FAIL b2b_saturate: zero_cnt=%0d want %0d", zero_cnt, model_cnt);
            n_err++;
        end
        step();
        send_word(16'h0000, 1'b1, 1'b0, 1'b0); // still saturated
        send_word(16'h0000, 1'b1, 1'b0, 1'b1); // clear beats increment
    endtask

    task automatic test_reset_mid_flight();
        send_word(16'h0000, 1'b1, 1'b0, 1'b0); // count back to 1
        in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b1;
        step(); // accept
        in_valid = 1'b0;
        step(); // mid-SCAN
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || zr !== 1'b0 || ng !== 1'b0 || zero_cnt !== 8'd0 || in_ready !== 1'b1) begin
            $display("FAIL reset_scan: vld=%b zr=%b ng=%b cnt=%0d rdy=%b want 0/0/0/0/1",
                     out_valid, zr, ng, zero_cnt, in_ready);
            n_err++;
        end
        model_cnt = 0;
        #3 rst_n = 1'b1;
        // Reset while presenting a negative word in DONE.
        in_valid = 1'b1; in_data = 16'h8000; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || ng !== 1'b0 || out_data !== 16'h0000 || zero_cnt !== 8'd0) begin
            $display("FAIL reset_done: vld=%b ng=%b data=%h cnt=%0d want 0/0/0000/0",
                     out_valid, ng, out_data, zero_cnt);
            n_err++;
        end
        #3 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_done_release: in_ready=%b want 1", in_ready);
            n_err++;
        end
        send_word(16'h00FF, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_word();
        test_nonzero_words();
        test_stall();
        test_back_to_back();
        test_reset_mid_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
